mips_run_ctrl: RTL and testbench

Run/debug sequencer that sits in front of the mips pipeline top. It loads program words into instruction memory and holds the core in reset while loading. It starts, pauses and single-steps the core through its `stall` input. When the core raises `halt`, it lets the pipeline drain, then freezes the core so the register file and data memory can be inspected.

---
 rtl/mips_run_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// ---------------------------------------------------------------------------
// mips_run_ctrl
//   Run/debug sequencer in front of the mips pipeline top. It loads program
//   words into instruction memory while the core is held in reset. It starts,
//   pauses and single-steps the core through its stall input. When the core
//   raises halt, it lets the pipeline drain, then freezes the core so that
//   architectural state can be inspected.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-low block reset
//   i_cmd_valid    command present
//   o_cmd_ready    command accepted when valid && ready at a rising edge
//   i_cmd_op       0 NOP, 1 LOAD, 2 RUN, 3 STEP, 4 PAUSE, 5 CLEAR, 6-7 NOP
//   i_cmd_data     instruction word for LOAD
//   o_imem_we      instruction memory write strobe (one-cycle pulse)
//   o_imem_addr    instruction memory word address
//   o_imem_wdata   instruction memory write data
//   o_cpu_reset    active-high reset to the core
//   o_cpu_stall    freeze to the core
//   i_cpu_halt     halt flag from the core
//   o_state        current state encoding
//   o_cycle_count  unstalled core cycles since CLEAR (saturating)
//   o_done         one-cycle pulse on entry to HALTED
//
// All outputs come straight from registers; an accepted command shows up on
// the outputs in the cycle after the accepting edge.
// ---------------------------------------------------------------------------
module mips_run_ctrl #(
   parameter int DATA_WIDTH      = 32,
   parameter int IMEM_ADDR_WIDTH = 8,
   parameter int DRAIN_CYCLES    = 4,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_cmd_valid,
   output logic                       o_cmd_ready,
   input  logic [2:0]                 i_cmd_op,
   input  logic [DATA_WIDTH-1:0]      i_cmd_data,
   output logic                       o_imem_we,
   output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
   output logic [DATA_WIDTH-1:0]      o_imem_wdata,
   output logic                       o_cpu_reset,
   output logic                       o_cpu_stall,
   input  logic                       i_cpu_halt,
   output logic [2:0]                 o_state,
   output logic [CNT_WIDTH-1:0]       o_cycle_count,
   output logic                       o_done
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_PAUSED = 3'd2,
      ST_STEP   = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_HALTED = 3'd5
   } state_t;

   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_RUN   = 3'd2;
   localparam logic [2:0] OP_STEP  = 3'd3;
   localparam logic [2:0] OP_PAUSE = 3'd4;
   localparam logic [2:0] OP_CLEAR = 3'd5;

   // Drain counter counts down from DRAIN_CYCLES-1 to 0, so DRAIN lasts
   // exactly DRAIN_CYCLES cycles.
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   state_t                     state_reg,     state_next;
   logic [DW-1:0]              drain_reg,     drain_next;
   logic [IMEM_ADDR_WIDTH-1:0] ptr_reg,       ptr_next;
   logic [CNT_WIDTH-1:0]       count_reg,     count_next;
   logic                       we_reg,        we_next;
   logic [IMEM_ADDR_WIDTH-1:0] addr_reg,      addr_next;
   logic [DATA_WIDTH-1:0]      wdata_reg,     wdata_next;
   logic                       cpu_reset_reg, cpu_reset_next;
   logic                       stall_reg,     stall_next;
   logic                       ready_reg,     ready_next;
   logic                       done_reg,      done_next;

   logic cmd_fire;
   logic clear_req;
   logic core_active;

   assign cmd_fire = i_cmd_valid && ready_reg;

   // Core clocks forward (and the cycle counter advances) only in these states.
   assign core_active = (state_reg == ST_RUN) || (state_reg == ST_STEP) ||
                        (state_reg == ST_DRAIN);

   always_comb begin
      state_next = state_reg;
      drain_next = drain_reg;
      ptr_next   = ptr_reg;
      count_next = count_reg;
      we_next    = 1'b0;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      clear_req  = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (cmd_fire) begin
               case (i_cmd_op)
                  OP_LOAD: begin
                     we_next    = 1'b1;
                     addr_next  = ptr_reg;
                     wdata_next = i_cmd_data;
                     ptr_next   = ptr_reg + 1'b1;   // wraps silently
                  end
                  OP_RUN:   state_next = ST_RUN;
                  OP_STEP:  state_next = ST_STEP;
                  OP_CLEAR: clear_req  = 1'b1;
                  default:  ;
               endcase
            end
         end

         ST_RUN: begin
            // Halt takes priority over any command issued in the same cycle.
            if (i_cpu_halt) begin
               state_next = ST_DRAIN;
               drain_next = DRAIN_LOAD;
            end else if (cmd_fire && (i_cmd_op == OP_PAUSE)) begin
               state_next = ST_PAUSED;
            end else if (cmd_fire && (i_cmd_op == OP_CLEAR)) begin
               state_next = ST_IDLE;
               clear_req  = 1'b1;
            end
         end

         ST_PAUSED: begin
            if (cmd_fire) begin
               case (i_cmd_op)
                  OP_RUN:  state_next = ST_RUN;
                  OP_STEP: state_next = ST_STEP;
                  OP_CLEAR: begin
                     state_next = ST_IDLE;
                     clear_req  = 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         ST_STEP: begin
            if (i_cpu_halt) begin
               state_next = ST_DRAIN;
               drain_next = DRAIN_LOAD;
            end else begin
               state_next = ST_PAUSED;
            end
         end

         ST_DRAIN: begin
            if (drain_reg == '0) begin
               state_next = ST_HALTED;
            end else begin
               drain_next = drain_reg - 1'b1;
            end
         end

         ST_HALTED: begin
            if (cmd_fire && (i_cmd_op == OP_CLEAR)) begin
               state_next = ST_IDLE;
               clear_req  = 1'b1;
            end
         end

         default: state_next = ST_IDLE;
      endcase

      // Saturating executed-cycle counter.
      if (core_active && (count_reg != '1)) begin
         count_next = count_reg + 1'b1;
      end

      if (clear_req) begin
         count_next = '0;
         ptr_next   = '0;
      end

      // Core control is a registered decode of the next state.
      cpu_reset_next = (state_next == ST_IDLE);
      stall_next     = !((state_next == ST_RUN) || (state_next == ST_STEP) ||
                         (state_next == ST_DRAIN));
      ready_next     = !((state_next == ST_STEP) || (state_next == ST_DRAIN));
      done_next      = (state_reg == ST_DRAIN) && (state_next == ST_HALTED);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         drain_reg     <= '0;
         ptr_reg       <= '0;
         count_reg     <= '0;
         we_reg        <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         cpu_reset_reg <= 1'b1;
         stall_reg     <= 1'b1;
         ready_reg     <= 1'b1;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         drain_reg     <= drain_next;
         ptr_reg       <= ptr_next;
         count_reg     <= count_next;
         we_reg        <= we_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         cpu_reset_reg <= cpu_reset_next;
         stall_reg     <= stall_next;
         ready_reg     <= ready_next;
         done_reg      <= done_next;
      end
   end

   assign o_state       = state_reg;
   assign o_cmd_ready   = ready_reg;
   assign o_imem_we     = we_reg;
   assign o_imem_addr   = addr_reg;
   assign o_imem_wdata  = wdata_reg;
   assign o_cpu_reset   = cpu_reset_reg;
   assign o_cpu_stall   = stall_reg;
   assign o_cycle_count = count_reg;
   assign o_done        = done_reg;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_run_ctrl
//   Directed testbench for mips_run_ctrl. A 4-bit instruction address and a
//   4-bit cycle counter are used so that pointer wrap and counter saturation
//   are reachable with short sequences.
// ---------------------------------------------------------------------------
module tb_mips_run_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int CW = 4;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_RUN   = 3'd2;
   localparam logic [2:0] OP_STEP  = 3'd3;
   localparam logic [2:0] OP_PAUSE = 3'd4;
   localparam logic [2:0] OP_CLEAR = 3'd5;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_cmd_valid;
   logic          o_cmd_ready;
   logic [2:0]    i_cmd_op;
   logic [DW-1:0] i_cmd_data;
   logic          o_imem_we;
   logic [AW-1:0] o_imem_addr;
   logic [DW-1:0] o_imem_wdata;
   logic          o_cpu_reset;
   logic          o_cpu_stall;
   logic          i_cpu_halt;
   logic [2:0]    o_state;
   logic [CW-1:0] o_cycle_count;
   logic          o_done;

   int checks = 0;
   int errors = 0;

   mips_run_ctrl #(
      .DATA_WIDTH(DW),
      .IMEM_ADDR_WIDTH(AW),
      .DRAIN_CYCLES(4),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .i_cmd_valid(i_cmd_valid),
      .o_cmd_ready(o_cmd_ready),
      .i_cmd_op(i_cmd_op),
      .i_cmd_data(i_cmd_data),
      .o_imem_we(o_imem_we),
      .o_imem_addr(o_imem_addr),
      .o_imem_wdata(o_imem_wdata),
      .o_cpu_reset(o_cpu_reset),
      .o_cpu_stall(o_cpu_stall),
      .i_cpu_halt(i_cpu_halt),
      .o_state(o_state),
      .o_cycle_count(o_cycle_count),
      .o_done(o_done)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command for exactly one edge.
   task automatic send(input logic [2:0] op, input logic [DW-1:0] data);
      i_cmd_valid = 1'b1;
      i_cmd_op    = op;
      i_cmd_data  = data;
      tick();
      i_cmd_valid = 1'b0;
      i_cmd_op    = OP_NOP;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      i_cpu_halt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         i_cmd_valid = 1'($urandom_range(0, 1));
         i_cmd_op    = 3'($urandom_range(0, 7));
         i_cmd_data  = $urandom;
         tick();
      end
      i_cmd_valid = 1'b0;
      i_cmd_op    = OP_NOP;
      i_cmd_data  = '0;
      checks++;
      if (o_state !== 3'd0 || o_cpu_reset !== 1'b1 || o_cpu_stall !== 1'b1 ||
          o_imem_we !== 1'b0 || o_cycle_count !== 4'd0 || o_cmd_ready !== 1'b1 ||
          o_done !== 1'b0 || o_imem_addr !== 4'd0 || o_imem_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: state=%0d rst=%b stall=%b we=%b cnt=%0d rdy=%b done=%b addr=%0d wdata=%h required 0 1 1 0 0 1 0 0 0",
                  o_state, o_cpu_reset, o_cpu_stall, o_imem_we, o_cycle_count,
                  o_cmd_ready, o_done, o_imem_addr, o_imem_wdata);
      end
      reset = 1'b1;
      tick();
      $display("reset: state=%0d cnt=%0d", o_state, o_cycle_count);
   endtask

   task automatic test_load();
      logic [DW-1:0] words [3];
      words[0] = 32'h2001000A;
      words[1] = 32'h20020014;
      words[2] = 32'h00221824;
      for (int i = 0; i < 3; i++) begin
         send(OP_LOAD, words[i]);
         checks++;
         if (o_imem_we !== 1'b1 || o_imem_addr !== 4'(i) || o_imem_wdata !== words[i]) begin
            errors++;
            $display("FAIL load_%0d: we=%b addr=%0d data=%h required 1 %0d %h",
                     i, o_imem_we, o_imem_addr, o_imem_wdata, i, words[i]);
         end
         $display("load: addr=%0d data=%h", o_imem_addr, o_imem_wdata);
      end
      tick();
      checks++;
      if (o_imem_we !== 1'b0) begin
         errors++;
         $display("FAIL load_we_pulse: we=%b required 0", o_imem_we);
      end
   endtask

   task automatic test_run_halt();
      int n;
      int dones;
      send(OP_RUN, '0);
      checks++;
      if (o_state !== 3'd1 || o_cpu_reset !== 1'b0 || o_cpu_stall !== 1'b0) begin
         errors++;
         $display("FAIL run_entry: state=%0d rst=%b stall=%b required 1 0 0",
                  o_state, o_cpu_reset, o_cpu_stall);
      end
      for (int i = 0; i < 9; i++) tick();
      i_cpu_halt = 1'b1;
      tick();                       // 10th RUN edge
      i_cpu_halt = 1'b0;
      checks++;
      if (o_state !== 3'd4 || o_cycle_count !== 4'd10 || o_cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL halt_to_drain: state=%0d cnt=%0d rdy=%b required 4 10 0",
                  o_state, o_cycle_count, o_cmd_ready);
      end
      n = 0;
      dones = 0;
      while (o_state === 3'd4 && n < 20) begin
         if (o_done === 1'b1) dones++;
         n++;
         tick();
      end
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL drain_length: cycles=%0d required 4", n);
      end
      if (o_done === 1'b1) dones++;
      checks++;
      if (o_state !== 3'd5 || o_done !== 1'b1 || o_cycle_count !== 4'd14 ||
          o_cpu_stall !== 1'b1 || o_cpu_reset !== 1'b0 || o_cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL halted_entry: state=%0d done=%b cnt=%0d stall=%b rst=%b rdy=%b required 5 1 14 1 0 1",
                  o_state, o_done, o_cycle_count, o_cpu_stall, o_cpu_reset, o_cmd_ready);
      end
      i_cpu_halt = 1'b1;            // halt ignored while HALTED
      for (int i = 0; i < 3; i++) begin
         tick();
         if (o_done === 1'b1) dones++;
      end
      i_cpu_halt = 1'b0;
      checks++;
      if (dones !== 1 || o_state !== 3'd5 || o_cycle_count !== 4'd14) begin
         errors++;
         $display("FAIL done_pulse: pulses=%0d state=%0d cnt=%0d required 1 5 14",
                  dones, o_state, o_cycle_count);
      end
      send(OP_CLEAR, '0);
      checks++;
      if (o_state !== 3'd0 || o_cycle_count !== 4'd0 || o_cpu_reset !== 1'b1) begin
         errors++;
         $display("FAIL clear_from_halted: state=%0d cnt=%0d rst=%b required 0 0 1",
                  o_state, o_cycle_count, o_cpu_reset);
      end
      send(OP_LOAD, 32'h1234_5678);
      checks++;
      if (o_imem_we !== 1'b1 || o_imem_addr !== 4'd0) begin
         errors++;
         $display("FAIL load_after_clear: we=%b addr=%0d required 1 0", o_imem_we, o_imem_addr);
      end
      $display("run_halt: drain=%0d done_pulses=%0d", n, dones);
   endtask

   task automatic test_step();
      send(OP_RUN, '0);
      send(OP_PAUSE, '0);
      checks++;
      if (o_state !== 3'd2 || o_cpu_stall !== 1'b1 || o_cpu_reset !== 1'b0 ||
          o_cycle_count !== 4'd1) begin
         errors++;
         $display("FAIL pause: state=%0d stall=%b rst=%b cnt=%0d required 2 1 0 1",
                  o_state, o_cpu_stall, o_cpu_reset, o_cycle_count);
      end
      for (int s = 0; s < 3; s++) begin
         send(OP_STEP, '0);
         checks++;
         if (o_state !== 3'd3 || o_cpu_stall !== 1'b0 || o_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL step_%0d_active: state=%0d stall=%b rdy=%b required 3 0 0",
                     s, o_state, o_cpu_stall, o_cmd_ready);
         end
         tick();
         checks++;
         if (o_state !== 3'd2 || o_cpu_stall !== 1'b1 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL step_%0d_return: state=%0d stall=%b rdy=%b required 2 1 1",
                     s, o_state, o_cpu_stall, o_cmd_ready);
         end
         $display("step %0d: cnt=%0d", s, o_cycle_count);
      end
      i_cpu_halt = 1'b1;            // halt ignored while PAUSED
      tick();
      i_cpu_halt = 1'b0;
      checks++;
      if (o_state !== 3'd2 || o_cycle_count !== 4'd4) begin
         errors++;
         $display("FAIL step_count: state=%0d cnt=%0d required 2 4", o_state, o_cycle_count);
      end
   endtask

   task automatic test_halt_pause_reset();
      int dones;
      dones = 0;
      send(OP_RUN, '0);
      i_cmd_valid = 1'b1;
      i_cmd_op    = OP_PAUSE;
      i_cpu_halt  = 1'b1;
      tick();
      i_cmd_valid = 1'b0;
      i_cmd_op    = OP_NOP;
      i_cpu_halt  = 1'b0;
      checks++;
      if (o_state !== 3'd4) begin
         errors++;
         $display("FAIL halt_beats_pause: state=%0d required 4", o_state);
      end
      tick();                       // second DRAIN cycle
      if (o_done === 1'b1) dones++;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (o_state !== 3'd0 || o_done !== 1'b0 || o_cpu_reset !== 1'b1 ||
          o_cpu_stall !== 1'b1 || o_cycle_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid_drain: state=%0d done=%b rst=%b stall=%b cnt=%0d required 0 0 1 1 0",
                  o_state, o_done, o_cpu_reset, o_cpu_stall, o_cycle_count);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (o_done === 1'b1) dones++;
      end
      checks++;
      if (dones !== 0 || o_state !== 3'd0) begin
         errors++;
         $display("FAIL no_done_after_reset: pulses=%0d state=%0d required 0 0", dones, o_state);
      end
      $display("halt_pause_reset: state=%0d", o_state);
   endtask

   task automatic test_wrap_saturate();
      int n;
      logic [DW-1:0] d;
      for (int i = 0; i < 17; i++) begin
         d = 32'hA500_0000 | 32'(i);
         send(OP_LOAD, d);
         checks++;
         if (o_imem_we !== 1'b1 || o_imem_addr !== 4'(i) || o_imem_wdata !== d) begin
            errors++;
            $display("FAIL wrap_load_%0d: we=%b addr=%0d data=%h required 1 %0d %h",
                     i, o_imem_we, o_imem_addr, o_imem_wdata, 4'(i), d);
         end
         $display("wrap load %0d: addr=%0d", i, o_imem_addr);
      end
      send(OP_RUN, '0);
      send(OP_LOAD, 32'hDEAD_BEEF);
      checks++;
      if (o_imem_we !== 1'b0 || o_state !== 3'd1) begin
         errors++;
         $display("FAIL load_in_run: we=%b state=%0d required 0 1", o_imem_we, o_state);
      end
      for (int i = 0; i < 19; i++) tick();
      i_cpu_halt = 1'b1;
      tick();
      i_cpu_halt = 1'b0;
      n = 0;
      while (o_state === 3'd4 && n < 20) begin
         n++;
         tick();
      end
      checks++;
      if (o_state !== 3'd5 || o_cycle_count !== 4'hF || n !== 4) begin
         errors++;
         $display("FAIL saturate: state=%0d cnt=%0d drain=%0d required 5 15 4",
                  o_state, o_cycle_count, n);
      end
      send(OP_CLEAR, '0);
      send(OP_LOAD, 32'h0BAD_F00D);
      checks++;
      if (o_state !== 3'd0 || o_cycle_count !== 4'd0 || o_cpu_reset !== 1'b1 ||
          o_imem_we !== 1'b1 || o_imem_addr !== 4'd0 || o_imem_wdata !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL wrap_clear_load: state=%0d cnt=%0d rst=%b we=%b addr=%0d required 0 0 1 1 0",
                  o_state, o_cycle_count, o_cpu_reset, o_imem_we, o_imem_addr);
      end
      $display("wrap_saturate: final addr=%0d", o_imem_addr);
   endtask

   initial begin
      reset       = 1'b0;
      i_cmd_valid = 1'b0;
      i_cmd_op    = OP_NOP;
      i_cmd_data  = '0;
      i_cpu_halt  = 1'b0;
      test_reset();
      test_load();
      test_run_halt();
      test_step();
      test_halt_pause_reset();
      test_wrap_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
